// File: rtl/keysearch_pkg.sv
// Shared register map constants and helpers for the DES key-search
// register file. Optional IRQ logic is gated by KEYSEARCH_IRQ_EN.
package keysearch_pkg;

  localparam logic [11:0] OFF_RUN    = 12'h000;
  localparam logic [11:0] OFF_BUSY   = 12'h004;
  localparam logic [11:0] OFF_DONE   = 12'h008;
  localparam logic [11:0] OFF_NCORES = 12'h00C;
  localparam logic [11:0] OFF_IRQEN  = 12'h010;
  localparam logic [11:0] OFF_GOALHI = 12'h018;
  localparam logic [11:0] OFF_GOALLO = 12'h01C;

  localparam logic [11:0] PERCORE_BASE   = 12'h800;
  localparam int          PERCORE_STRIDE = 16;

  localparam logic [1:0] SUB_STARTHI = 2'd0;
  localparam logic [1:0] SUB_STARTLO = 2'd1;
  localparam logic [1:0] SUB_RESHI   = 2'd2;
  localparam logic [1:0] SUB_RESLO   = 2'd3;

  localparam logic [31:0] PARITY_MASK = 32'hfefefefe;
  localparam logic [31:0] NO_MASK     = 32'hffffffff;

  // Byte-strobed merge; written bytes are ANDed with msk.
  function automatic logic [31:0] be_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be,
    input logic [31:0] msk
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8] & msk[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/keysearch_core_slot.sv
// Per-core state: start key, busy fall detector, sticky DONE
// and RUN bit with auto-clear on completion.
module keysearch_core_slot
  import keysearch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wr_hi_i,
  input  logic        wr_lo_i,
  input  logic        run_we_i,
  input  logic        run_wd_i,
  input  logic        done_clr_i,
  input  logic        busy_i,
  output logic [63:0] start_o,
  output logic        run_o,
  output logic        done_o
);

  logic [63:0] start_q, start_d;
  logic        run_q, run_d;
  logic        done_q, done_d;
  logic        busy_q;
  logic        fall;

  // Next state: software RUN write beats auto-clear, DONE set beats W1C.
  always_comb begin
    fall    = busy_q & ~busy_i;
    start_d = start_q;
    if (wr_hi_i)
      start_d[63:32] = be_merge(start_q[63:32], wdata_i, wstrb_i, PARITY_MASK);
    if (wr_lo_i)
      start_d[31:0] = be_merge(start_q[31:0], wdata_i, wstrb_i, PARITY_MASK);
    run_d  = run_we_i ? run_wd_i : (run_q & ~fall);
    done_d = fall | (done_q & ~done_clr_i);
  end

  // Slot state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= start_d;
      run_q   <= run_d;
      done_q  <= done_d;
      busy_q  <= busy_i;
    end
  end

  assign start_o = start_q;
  assign run_o   = run_q;
  assign done_o  = done_q;

endmodule

// File: rtl/keysearch_regs.sv
// ARM-side register file for an N-core DES key-search array.
// KEYSEARCH_IRQ_EN adds the IRQEN register and the irq output.
module keysearch_regs
  import keysearch_pkg::*;
#(
  parameter int N  = 1,
  parameter int AW = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     armaddr,
  output logic [31:0]     armrdata,
  input  logic [31:0]     armwdata,
  input  logic            armwr,
  input  logic            armreq,
  output logic            armack,
  input  logic [3:0]      armwstrb,
  output logic            armerr,
  output logic            irq,
  output logic [63:0]     goal,
  output logic [64*N-1:0] start,
  output logic [N-1:0]    run,
  input  logic [N-1:0]    busy,
  input  logic [64*N-1:0] res
);

  localparam int PCS = $clog2(PERCORE_STRIDE);
  localparam int IW  = AW - PCS;

  logic          req_q, ack_q, err_q;
  logic [31:0]   rdata_q;
  logic [63:0]   goal_q;
  logic [N-1:0]  done_w;
  logic [AW-1:0] off;
  logic [IW-1:0] idx;
  logic [1:0]    sub;
  logic          accept, in_pc, ro, err_d, err_a, wr_ok;
  logic          is_run, is_busy, is_done, is_nc, is_ghi, is_glo;
  logic [31:0]   rd_d, rdata_a;
  logic [63:0]   c_start, c_res;
  logic          unused_addr;

  assign unused_addr = ^{armaddr >> AW, armaddr[1:0]};

  assign accept = armreq & ~req_q;
  assign off    = {armaddr[AW-1:2], 2'b00};
  assign idx    = off[AW-1:PCS] - IW'(PERCORE_BASE >> PCS);
  assign sub    = off[3:2];
  assign in_pc  = (off >= AW'(PERCORE_BASE)) && (idx < IW'(N));
  assign is_run  = off == AW'(OFF_RUN);
  assign is_busy = off == AW'(OFF_BUSY);
  assign is_done = off == AW'(OFF_DONE);
  assign is_nc   = off == AW'(OFF_NCORES);
  assign is_ghi  = off == AW'(OFF_GOALHI);
  assign is_glo  = off == AW'(OFF_GOALLO);

`ifdef KEYSEARCH_IRQ_EN
  logic         is_irqen;
  logic [N-1:0] irqen_q;
  logic         irq_q;
  assign is_irqen = off == AW'(OFF_IRQEN);
`endif

  // Select the addressed core's start key and result.
  always_comb begin
    c_start = '0;
    c_res   = '0;
    for (int i = 0; i < N; i++)
      if (idx == IW'(i)) begin
        c_start = start[64*i +: 64];
        c_res   = res[64*i +: 64];
      end
  end

  // Address decode and read mux.
  always_comb begin
    rd_d  = '0;
    err_d = 1'b1;
    ro    = 1'b0;
    unique case (1'b1)
      is_run:  begin err_d = 1'b0; rd_d[N-1:0] = run; end
      is_busy: begin err_d = 1'b0; ro = 1'b1; rd_d[N-1:0] = busy; end
      is_done: begin err_d = 1'b0; rd_d[N-1:0] = done_w; end
      is_nc:   begin err_d = 1'b0; ro = 1'b1; rd_d = 32'(N); end
`ifdef KEYSEARCH_IRQ_EN
      is_irqen: begin err_d = 1'b0; rd_d[N-1:0] = irqen_q; end
`endif
      is_ghi:  begin err_d = 1'b0; rd_d = goal_q[63:32]; end
      is_glo:  begin err_d = 1'b0; rd_d = goal_q[31:0]; end
      in_pc: begin
        err_d = 1'b0;
        ro    = sub[1];
        unique case (sub)
          SUB_STARTHI: rd_d = c_start[63:32];
          SUB_STARTLO: rd_d = c_start[31:0];
          SUB_RESHI:   rd_d = c_res[63:32];
          SUB_RESLO:   rd_d = c_res[31:0];
          default:     rd_d = '0;
        endcase
      end
      default: ;
    endcase
    err_a   = err_d | (armwr & ro);
    rdata_a = (armwr | err_a) ? 32'h0 : rd_d;
    wr_ok   = accept & armwr & ~err_a;
  end

  for (genvar i = 0; i < N; i++) begin : g_slot
    keysearch_core_slot u_slot (
      .clk        (clk),
      .rst        (rst),
      .wdata_i    (armwdata),
      .wstrb_i    (armwstrb),
      .wr_hi_i    (wr_ok & in_pc & (idx == IW'(i)) & (sub == SUB_STARTHI)),
      .wr_lo_i    (wr_ok & in_pc & (idx == IW'(i)) & (sub == SUB_STARTLO)),
      .run_we_i   (wr_ok & is_run & armwstrb[i/8]),
      .run_wd_i   (armwdata[i]),
      .done_clr_i (wr_ok & is_done & armwstrb[i/8] & armwdata[i]),
      .busy_i     (busy[i]),
      .start_o    (start[64*i +: 64]),
      .run_o      (run[i]),
      .done_o     (done_w[i])
    );
  end

  // Handshake, read data capture and goal register.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      goal_q  <= '0;
    end else begin
      req_q   <= armreq;
      ack_q   <= accept;
      err_q   <= accept & err_a;
      rdata_q <= accept ? rdata_a : 32'h0;
      if (wr_ok && is_ghi)
        goal_q[63:32] <= be_merge(goal_q[63:32], armwdata, armwstrb, NO_MASK);
      if (wr_ok && is_glo)
        goal_q[31:0] <= be_merge(goal_q[31:0], armwdata, armwstrb, NO_MASK);
    end
  end

`ifdef KEYSEARCH_IRQ_EN
  // IRQ enable register and registered interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      irqen_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        if (wr_ok && is_irqen && armwstrb[i/8]) irqen_q[i] <= armwdata[i];
      irq_q <= |(done_w & irqen_q);
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign armack   = ack_q;
  assign armerr   = err_q;
  assign armrdata = rdata_q;
  assign goal     = goal_q;

endmodule
